// File: rtl/count_dir_pkg.sv
// Shared definitions for the direction controller: FSM encodings and
// the debounce counter width (wide enough for DB_CYCLES up to 255).
package count_dir_pkg;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        BNC_UP = 2'd1,
        BNC_DN = 2'd2
    } mode_t;

    localparam int DB_CNT_W = 8;

endpackage

// File: rtl/btn_debounce.sv
// Raw pushbutton conditioning: 2-flop synchronizer, counting debouncer
// and registered rising-edge detector producing a one-cycle press pulse.
module btn_debounce
    import count_dir_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_CYCLES - 1);

    logic                sync_1;
    logic                sync_2;
    logic                db_level;
    logic                db_level_d;
    logic [DB_CNT_W-1:0] db_cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
        end
    end

    // Accept a new level after DB_CYCLES consecutive differing samples;
    // a sample equal to the current level restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_level <= 1'b0;
            db_cnt   <= '0;
        end else if (sync_2 != db_level) begin
            if (db_cnt == DB_LAST) begin
                db_level <= sync_2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // Registered one-cycle pulse on a debounced 0->1 transition only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_level_d <= 1'b0;
            press      <= 1'b0;
        end else begin
            db_level_d <= db_level;
            press      <= db_level & ~db_level_d;
        end
    end

endmodule

// File: rtl/count_dir_ctrl.sv
// Direction controller for a 3-bit up/down counter: manual toggling by a
// debounced button, or automatic bouncing between LO_LIM and HI_LIM.
// sel changes on the edge where the counter reaches a limit, so each
// limit value is seen for exactly one cycle.
module count_dir_ctrl
    import count_dir_pkg::*;
#(
    parameter int         DB_CYCLES = 4,
    parameter logic [2:0] LO_LIM    = 3'd0,
    parameter logic [2:0] HI_LIM    = 3'd7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       bounce_en,
    input  logic [2:0] q_in,
    output logic       sel,
    output logic       turn,
    output logic [1:0] mode
);

    // Turn one value early because the counter steps on the same edge.
    localparam logic [2:0] HI_TURN = HI_LIM - 3'd1;
    localparam logic [2:0] LO_TURN = LO_LIM + 3'd1;

    logic  press;
    logic  sel_q;
    logic  sel_next;
    logic  sel_tog;
    logic  turn_q;
    mode_t state_q;
    mode_t state_next;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .press (press)
    );

    // State, direction and turn-pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MANUAL;
            sel_q   <= 1'b0;
            turn_q  <= 1'b0;
        end else begin
            state_q <= state_next;
            sel_q   <= sel_next;
            turn_q  <= (sel_next != sel_q);
        end
    end

    // Next state and next direction; leaving bounce mode has priority
    // over limit detection so sel is held on exit.
    always_comb begin
        state_next = state_q;
        sel_next   = sel_q;
        sel_tog    = sel_q ^ press;
        case (state_q)
            MANUAL: begin
                sel_next = sel_tog;
                if (bounce_en) begin
                    state_next = sel_tog ? BNC_DN : BNC_UP;
                end
            end
            BNC_UP: begin
                if (!bounce_en) begin
                    state_next = MANUAL;
                end else if ((q_in == HI_TURN) || (q_in >= HI_LIM)) begin
                    state_next = BNC_DN;
                    sel_next   = 1'b1;
                end else begin
                    sel_next = 1'b0;
                end
            end
            BNC_DN: begin
                if (!bounce_en) begin
                    state_next = MANUAL;
                end else if ((q_in == LO_TURN) || (q_in <= LO_LIM)) begin
                    state_next = BNC_UP;
                    sel_next   = 1'b0;
                end else begin
                    sel_next = 1'b1;
                end
            end
            default: begin
                state_next = MANUAL;
            end
        endcase
    end

    assign sel  = sel_q;
    assign turn = turn_q;
    assign mode = state_q;

endmodule

// File: doc/count_dir_ctrl.md
COUNT_DIR_CTRL -- requirements
Module: count_dir_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 4: consecutive stable synchronized samples required to accept a button level change (range 2..255).
REQ-002 Parameter LO_LIM, default 3'd0: lower turnaround value in bounce mode.
REQ-003 Parameter HI_LIM, default 3'd7: upper turnaround value in bounce mode; LO_LIM+2 <= HI_LIM is required.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  asynchronous, active-low reset (asserted when 0).
REQ-006 btn  in  1  raw, asynchronous direction-toggle pushbutton, active-high.
REQ-007 bounce_en  in  1  1 = automatic bounce mode, 0 = manual mode; synchronous, sampled each cycle.
REQ-008 q_in  in  3  current value of the downstream 3-bit up/down counter.
REQ-009 sel  out  1  direction to the downstream counter: 0 = count up, 1 = count down; registered.
REQ-010 turn  out  1  one-cycle pulse, high in the cycle after sel changes value; registered.
REQ-011 mode  out  2  current FSM state encoding (MANUAL=0, BNC_UP=1, BNC_DN=2); registered.

Function
REQ-012 btn shall pass through a 2-flop synchronizer before any other use.
REQ-013 Debounce: a counter shall accept a new debounced level only after DB_CYCLES consecutive equal synchronized samples differing from the current debounced level; any mismatching sample shall clear the counter.
REQ-014 A press event shall be a single-cycle pulse on a debounced 0->1 transition; 1->0 transitions produce no event.
REQ-015 Press-to-sel latency in MANUAL shall be exactly 2 (sync) + DB_CYCLES + 1 cycles from the first stable high btn sample.
REQ-016 FSM states: MANUAL, BNC_UP, BNC_DN; no other reachable states; an illegal encoding shall return to MANUAL on the next edge.
REQ-017 MANUAL: each press event shall toggle sel; with bounce_en=1 the next state shall be BNC_UP if sel=0, else BNC_DN, and sel is unchanged on that transition.
REQ-018 BNC_UP: if q_in == HI_LIM-1, or q_in >= HI_LIM, the next state shall be BNC_DN and sel shall be set to 1 on the same edge; otherwise sel stays 0.
REQ-019 BNC_DN: if q_in == LO_LIM+1, or q_in <= LO_LIM, the next state shall be BNC_UP and sel shall be set to 0 on the same edge; otherwise sel stays 1.
REQ-020 With the downstream counter stepping every cycle, REQ-018/019 shall yield the sequence LO..HI..LO with each limit value present for exactly one cycle and no wrap-around.
REQ-021 Press events in BNC_UP/BNC_DN shall be ignored.
REQ-022 bounce_en=0 in either bounce state shall return to MANUAL on the next edge with sel held at its current value.
REQ-023 Simultaneous press event and bounce_en 0->1 in MANUAL: the toggle applies first, and the bounce state is chosen from the toggled sel.
REQ-024 turn shall equal (sel_next != sel) registered, so it is high for exactly one cycle per direction change from any cause.

Reset
REQ-025 While rst=0: sel=0, turn=0, mode=MANUAL, synchronizer flops=0, debounced level=0, debounce counter=0, asynchronously.
REQ-026 Reset deassertion mid-press shall require a full fresh debounce before any event; reset during bounce shall abandon the bounce and restart in MANUAL.

Structure
REQ-027 The FSM state encodings and the width of the debounce counter (ceil(log2(256))=8) shall live in a shared package, count_dir_pkg.
REQ-028 Synchronizer, debounce and edge detection shall form one sub-module, btn_debounce (ports clk, rst, btn, press); the FSM stays in count_dir_ctrl.

Verification
REQ-029 Reset: hold rst=0 for 3 cycles with btn=1, bounce_en=1 -> sel=0, turn=0, mode=0 throughout; after release, mode=BNC_UP one cycle later.
REQ-030 Debounce: btn glitch high 3 cycles (DB_CYCLES=4) -> no toggle; btn high 10 cycles -> sel 0->1 exactly 7 cycles after first high sample, turn high 1 cycle.
REQ-031 Bounce with behavioural counter model: from q_in=0, sel=0, bounce_en=1 -> q sequence 0,1,..,7,6,..,0,1, each limit held exactly one cycle, turn pulses once per limit.
REQ-032 Out-of-range start, LO_LIM=2, HI_LIM=5: BNC_DN with q_in=0 -> sel=0 next edge; BNC_UP with q_in=7 -> sel=1 next edge.
REQ-033 Mode exit: drop bounce_en while in BNC_DN with q_in=4 -> mode=MANUAL next edge, sel stays 1, turn stays 0; press in bounce mode -> no sel change.
REQ-034 Simultaneous: press event and bounce_en rising in the same cycle with sel=0 -> sel=1, mode=BNC_DN, turn=1 next cycle.
